// File: rtl/nr_div_pkg.sv
// rtl/nr_div_pkg.sv - shared types and Q2.6 constants for the Newton-Raphson divider
package nr_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_D = 3'd1,
    MUL_X = 3'd2,
    MUL_Q = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  TWO_Q26  = 8'h80;
  localparam logic [7:0]  SAT_Q26  = 8'hFF;
  localparam logic [15:0] ERR_QUOT = 16'hFFFF;

endpackage

// File: rtl/nr_div_ctrl_if.sv
// rtl/nr_div_ctrl_if.sv - request/result bundle between a requester and the divider
interface nr_div_ctrl_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] quotient;
  logic [7:0]  recip;

  modport master (output start, a, b, input busy, done, err, quotient, recip);
  modport slave  (input start, a, b, output busy, done, err, quotient, recip);
endinterface

// File: rtl/nr_mul8.sv
// rtl/nr_mul8.sv - combinational 8x8 unsigned multiplier shared by all divider steps
module nr_mul8 (
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic [15:0] prod
);

  assign prod = {8'd0, op_a} * {8'd0, op_b};

endmodule

// File: rtl/nr_div_ctrl.sv
// rtl/nr_div_ctrl.sv - Newton-Raphson reciprocal divider controller; option NR_DIV_EARLY_EXIT_EN
module nr_div_ctrl
  import nr_div_pkg::*;
#(
  parameter int         ITERS = 3,
  parameter logic [7:0] X0    = 8'h60
) (
  input  logic          clk,
  input  logic          rst_n,
  nr_div_ctrl_if.slave  bus
);

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [7:0]  x, d;
  logic [2:0]  iter, iter_next;
  logic        done_q, err_q;
  logic [15:0] quot_q;
  logic [7:0]  recip_q;

  logic [7:0]  mul_a, mul_b;
  logic [15:0] prod;
  logic [7:0]  f, x_new;
  logic        more_iters, exit_iter;

  nr_mul8 u_mul (
    .op_a (mul_a),
    .op_b (mul_b),
    .prod (prod)
  );

  // Correction factor 2 - b*x, floored at zero so an overshooting estimate cannot wrap.
  assign f         = (d > TWO_Q26) ? 8'h00 : (TWO_Q26 - d);
  // New estimate x*(2-b*x) rescaled back to Q2.6, saturating if it would exceed the range.
  assign x_new     = (prod[15:14] != 2'b00) ? SAT_Q26 : prod[13:6];
  assign iter_next = iter + 3'd1;
  assign more_iters = int'(iter_next) < ITERS;

`ifdef NR_DIV_EARLY_EXIT_EN
  assign exit_iter = !more_iters || (x_new == x);
`else
  assign exit_iter = !more_iters;
`endif

  // Route the one multiplier: b*x while refining, x*f for the update, a*x for the quotient.
  always_comb begin
    mul_a = 8'h00;
    mul_b = 8'h00;
    case (state)
      MUL_D: begin mul_a = b_q; mul_b = x;   end
      MUL_X: begin mul_a = x;   mul_b = f;   end
      MUL_Q: begin mul_a = a_q; mul_b = x;   end
      default: ;
    endcase
  end

  // Next-state selection; a non-normalized divisor short-circuits straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = bus.b[7] ? MUL_D : DONE;
      MUL_D:   state_nxt = MUL_X;
      MUL_X:   state_nxt = exit_iter ? MUL_Q : MUL_D;
      MUL_Q:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, iteration datapath and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      x       <= 8'h00;
      d       <= 8'h00;
      iter    <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      quot_q  <= 16'h0000;
      recip_q <= 8'h00;
    end else begin
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.b[7]) begin
              a_q  <= bus.a;
              b_q  <= bus.b;
              x    <= X0;
              iter <= 3'd0;
            end else begin
              err_q   <= 1'b1;
              quot_q  <= ERR_QUOT;
              recip_q <= SAT_Q26;
            end
          end
        end
        MUL_D: d <= prod[15:8];
        MUL_X: begin
          x    <= x_new;
          iter <= iter_next;
        end
        MUL_Q: begin
          quot_q  <= prod;
          recip_q <= x;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.quotient = quot_q;
  assign bus.recip    = recip_q;

endmodule

// File: tb/tb_nr_div_ctrl.sv
// tb/tb_nr_div_ctrl.sv - randomized self-checking bench for nr_div_ctrl at ITERS=3 and ITERS=7
module tb_nr_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nr_div_ctrl_if if3 ();
  nr_div_ctrl_if if7 ();

  nr_div_ctrl #(.ITERS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  nr_div_ctrl #(.ITERS(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

`ifdef NR_DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Division as arithmetic on integers: returns edge count to done, err flag and results.
  function automatic void nr_model(input logic [7:0] ai, input logic [7:0] bi, input int iters,
                                   output int lat, output logic e,
                                   output logic [15:0] q, output logic [7:0] r);
    int xv, dv, fv, pv, nx, k;
    if (!bi[7]) begin
      lat = 1; e = 1'b1; q = 16'hFFFF; r = 8'hFF;
      return;
    end
    xv = 'h60;
    k = 0;
    while (k < iters) begin
      dv = (int'(bi) * xv) / 256;
      fv = (dv > 128) ? 0 : 128 - dv;
      pv = xv * fv;
      nx = (pv >= 16384) ? 255 : pv / 64;
      k++;
      if (EARLY && nx == xv) break;
      xv = nx;
    end
    lat = 2 * k + 1;
    e = 1'b0;
    q = 16'(int'(ai) * xv);
    r = 8'(xv);
  endfunction

  // Model state per instance (0: ITERS=3, 1: ITERS=7).
  int          lat_left [2];
  bit          done_now [2];
  logic        m_err    [2];
  logic [15:0] m_q      [2];
  logic [7:0]  m_r      [2];
  logic        p_err    [2];
  logic [15:0] p_q      [2];
  logic [7:0]  p_r      [2];

  function automatic int iters_of(input int i);
    return (i == 0) ? 3 : 7;
  endfunction

  // Advance the model on each rising edge using the inputs as the DUT sees them.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        lat_left[i] = 0; done_now[i] = 0;
        m_err[i] = 0; m_q[i] = 0; m_r[i] = 0;
      end else if (done_now[i]) begin
        done_now[i] = 0;
      end else if (lat_left[i] > 0) begin
        lat_left[i]--;
        if (lat_left[i] == 0) begin
          done_now[i] = 1;
          m_err[i] = p_err[i]; m_q[i] = p_q[i]; m_r[i] = p_r[i];
        end
      end else if (if3.start) begin
        int lat;
        logic e;
        logic [15:0] q;
        logic [7:0] r;
        nr_model(if3.a, if3.b, iters_of(i), lat, e, q, r);
        if (e) begin
          done_now[i] = 1;
          m_err[i] = 1; m_q[i] = q; m_r[i] = r;
        end else begin
          lat_left[i] = lat;
          p_err[i] = e; p_q[i] = q; p_r[i] = r;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic err,
                          input logic [15:0] q, input logic [7:0] r);
    string s;
    s = (i == 0) ? "it3" : "it7";
    if (!rst_n) begin
      chk({s, "_rst_busy"}, busy, 0);
      chk({s, "_rst_done"}, done, 0);
      chk({s, "_rst_err"}, err, 0);
      chk({s, "_rst_quot"}, q, 0);
      chk({s, "_rst_recip"}, r, 0);
    end else begin
      chk({s, "_busy"}, busy, (lat_left[i] > 0 || done_now[i]) ? 1 : 0);
      chk({s, "_done"}, done, done_now[i] ? 1 : 0);
      if (lat_left[i] == 0) begin
        chk({s, "_err"}, err, m_err[i]);
        chk({s, "_quot"}, q, m_q[i]);
        chk({s, "_recip"}, r, m_r[i]);
      end
    end
  endtask

  // Compare both instances against the model every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, if3.busy, if3.done, if3.err, if3.quotient, if3.recip);
      cmp_inst(1, if7.busy, if7.done, if7.err, if7.quotient, if7.recip);
    end
  end

  task automatic set_in(input logic s, input logic [7:0] av, input logic [7:0] bv);
    if3.start = s; if3.a = av; if3.b = bv;
    if7.start = s; if7.a = av; if7.b = bv;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((if3.busy || if7.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (if3.busy || if7.busy) ? 1 : 0, 0);
  endtask

  initial begin
    int lat;
    logic e;
    logic [15:0] q;
    logic [7:0] r;
    int n3, n7, cnt3, cnt7;

    // Pin the model to hand-derived values.
    nr_model(8'h80, 8'h80, 1, lat, e, q, r);
    chk("model_x1", r, 8'h78);
    nr_model(8'h80, 8'h80, 2, lat, e, q, r);
    chk("model_x2", r, 8'h7F);
    nr_model(8'h80, 8'h80, 3, lat, e, q, r);
    chk("model_x3", r, 8'h80);
    chk("model_q3", q, 16'h4000);
    chk("model_lat3", lat, 7);
    nr_model(8'h80, 8'h80, 7, lat, e, q, r);
    chk("model_lat7", lat, EARLY ? 9 : 15);
    chk("model_q7", q, 16'h4000);
    nr_model(8'h55, 8'h40, 3, lat, e, q, r);
    chk("model_err", {e, q, r}, {1'b1, 16'hFFFF, 8'hFF});

    set_in(0, 8'h00, 8'h80);
    #1 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed 0x80/0x80 division, latency measured from the accept edge.
    @(posedge clk); #2 set_in(1, 8'h80, 8'h80);
    @(posedge clk); #2 set_in(0, 8'h11, 8'h22);
    n3 = 0; n7 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (if3.done && n3 == 0) begin
        n3 = n;
        chk("dir_quot3", if3.quotient, 16'h4000);
        chk("dir_recip3", if3.recip, 8'h80);
        chk("dir_err3", if3.err, 0);
      end
      if (if7.done && n7 == 0) begin
        n7 = n;
        chk("dir_quot7", if7.quotient, 16'h4000);
      end
    end
    chk("dir_lat3", n3, 7);
    chk("dir_lat7", n7, EARLY ? 9 : 15);

    // Non-normalized divisor, then a valid division clears err.
    @(posedge clk); #2 set_in(1, 8'h33, 8'h40);
    @(posedge clk); #2 set_in(0, 8'h33, 8'h40);
    @(negedge clk);
    chk("err_done", if3.done, 1);
    chk("err_flag", if3.err, 1);
    chk("err_quot", if3.quotient, 16'hFFFF);
    chk("err_recip", if3.recip, 8'hFF);
    wait_idle(40);
    @(posedge clk); #2 set_in(1, 8'hC0, 8'h80);
    @(posedge clk); #2 set_in(0, 8'h00, 8'h00);
    wait_idle(40);
    chk("err_cleared", if3.err, 0);

    // Start re-pulsed during MUL_X with different operands is ignored.
    @(posedge clk); #2 set_in(1, 8'h80, 8'h80);
    @(posedge clk); #2 set_in(0, 8'h80, 8'h80);
    @(posedge clk); #2 set_in(1, 8'hFF, 8'hC3);
    @(posedge clk); #2 set_in(0, 8'h00, 8'h00);
    cnt3 = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (if3.done) cnt3++;
    end
    chk("ignore_one_done", cnt3, 1);
    chk("ignore_quot", if3.quotient, 16'h4000);
    wait_idle(40);

    // Reset during MUL_D of the second iteration.
    @(posedge clk); #2 set_in(1, 8'h80, 8'h80);
    @(posedge clk); #2 set_in(0, 8'h80, 8'h80);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", if3.busy, 0);
    chk("midrst_quot", if3.quotient, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1; set_in(1, 8'hA0, 8'h90);
    @(posedge clk); #2 set_in(0, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_rst_accept", if3.busy, 1);
    wait_idle(40);

    // Start held high: back-to-back divisions.
    @(posedge clk); #2 set_in(1, 8'h80, 8'h80);
    cnt3 = 0; cnt7 = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (if3.done) cnt3++;
      if (if7.done) cnt7++;
    end
    chk("held_dones3", cnt3, 2);
    chk("held_dones7", cnt7, 1);
    #1 set_in(0, 8'h00, 8'h00);
    wait_idle(40);

    // Randomized traffic, including starts while busy and non-normalized divisors.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] ra, rb;
      @(posedge clk);
      #2;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? (rb & 8'h7F) : (rb | 8'h80);
      set_in(($urandom_range(0, 2) == 0), ra, rb);
    end
    set_in(0, 8'h00, 8'h00);
    wait_idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
